// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared AXI4-Lite definitions used by the slave endpoint and the CPU-side
// master interface.
//   RESP_*        : B/R response codes
//   PROT_DEFAULT  : AxPROT value the master drives by default
//   slv_state_e   : slave endpoint FSM state encoding
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] PROT_DEFAULT = 3'b000;

   typedef enum logic [2:0] {
      SLV_IDLE,
      SLV_W_COLLECT,   // exactly one of AW / W captured
      SLV_W_ACCESS,
      SLV_W_RESP,
      SLV_R_ACCESS,
      SLV_R_RESP
   } slv_state_e;

endpackage

// File: rtl/axil_slv_addr_decode.sv
// -----------------------------------------------------------------------------
// axil_slv_addr_decode
// Combinational window check for one AXI4-Lite slave, plus offset from the
// window base with the byte-lane bits cleared.
//   addr     in   absolute byte address
//   in_range out  BASE_ADDR <= addr < BASE_ADDR + ADDR_SPAN
//   offset   out  addr - BASE_ADDR, bits [1:0] forced to 0
// -----------------------------------------------------------------------------
module axil_slv_addr_decode #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = ADDR_WIDTH'(32'h0000_1000)
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic                  in_range,
   output logic [ADDR_WIDTH-1:0] offset
);

   // One extra bit so the subtraction borrow tells us addr < BASE_ADDR without
   // ever forming BASE_ADDR + ADDR_SPAN (which could wrap at the top of memory).
   logic [ADDR_WIDTH:0] diff;

   assign diff     = {1'b0, addr} - {1'b0, BASE_ADDR};
   assign in_range = ~diff[ADDR_WIDTH] && (diff[ADDR_WIDTH-1:0] < ADDR_SPAN);
   assign offset   = {diff[ADDR_WIDTH-1:2], 2'b00};

endmodule

// File: rtl/axi4_lite_slave_if.sv
// -----------------------------------------------------------------------------
// axi4_lite_slave_if
// AXI4-Lite slave endpoint that turns one AXI transaction at a time into a
// req/ack access on a simple peripheral register bus.
//   clk, rst            : clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*     : AXI4-Lite write channels (AWPROT ignored)
//   S_AXI_AR*/R*        : AXI4-Lite read channels (ARPROT ignored)
//   reg_addr/wdata/wstrb/wr/req : register-bus request, held until reg_ack
//   reg_rdata/ack/err   : register-bus completion (err -> SLVERR)
// Optional build macro AXIL_SLV_TIMEOUT_EN: abort an access with SLVERR when
// reg_ack has not arrived after TIMEOUT_CYCLES cycles of reg_req.
// -----------------------------------------------------------------------------
module axi4_lite_slave_if
   import axi4_lite_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(32'h0000_0000),
   parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN      = ADDR_WIDTH'(32'h0000_1000),
   parameter int                    TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]            S_AXI_AWPROT,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   input  logic [31:0]           S_AXI_WDATA,
   input  logic [3:0]            S_AXI_WSTRB,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   output logic [1:0]            S_AXI_BRESP,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]            S_AXI_ARPROT,
   input  logic                  S_AXI_ARVALID,
   output logic                  S_AXI_ARREADY,
   output logic [31:0]           S_AXI_RDATA,
   output logic [1:0]            S_AXI_RRESP,
   output logic                  S_AXI_RVALID,
   input  logic                  S_AXI_RREADY,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [31:0]           reg_wdata,
   output logic [3:0]            reg_wstrb,
   output logic                  reg_wr,
   output logic                  reg_req,
   input  logic [31:0]           reg_rdata,
   input  logic                  reg_ack,
   input  logic                  reg_err
);

   slv_state_e state, state_n;

   logic                  aw_got, w_got;
   logic                  rd_prio;      // 1: read wins the next contested cycle
   logic                  dec_err;      // current access missed the window
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;

   logic                  wr_pend, in_idle, capt_st, contested;
   logic                  arready_c, awready_c, wready_c;
   logic                  rd_grant, aw_hs, w_hs, w_go;
   logic                  ack_hit, acc_done, timeout_hit;
   logic [1:0]            resp_c;
   logic [ADDR_WIDTH-1:0] acc_addr, dec_off;
   logic                  dec_hit;

   // AxPROT carries nothing this endpoint acts on.
   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   // -------------------------------------------------------------------------
   // Next-state / handshake logic
   // -------------------------------------------------------------------------
   always_comb begin
      wr_pend   = S_AXI_AWVALID | S_AXI_WVALID;
      in_idle   = (state == SLV_IDLE);
      capt_st   = in_idle | (state == SLV_W_COLLECT);
      // Readies are forced low while reset is held so every output reads 0.
      arready_c = ~rst & in_idle & (~wr_pend | rd_prio);
      rd_grant  = arready_c & S_AXI_ARVALID;
      awready_c = ~rst & capt_st & ~aw_got & ~rd_grant;
      wready_c  = ~rst & capt_st & ~w_got  & ~rd_grant;
      aw_hs     = awready_c & S_AXI_AWVALID;
      w_hs      = wready_c & S_AXI_WVALID;
      contested = in_idle & S_AXI_ARVALID & wr_pend;
      // Address of the access about to start: live on the handshake cycle,
      // otherwise the previously latched AW address.
      acc_addr  = rd_grant ? S_AXI_ARADDR : (aw_hs ? S_AXI_AWADDR : aw_addr_q);
      ack_hit   = reg_req & reg_ack;
      acc_done  = dec_err | ack_hit | timeout_hit;
      if (dec_err)      resp_c = RESP_DECERR;
      else if (ack_hit) resp_c = reg_err ? RESP_SLVERR : RESP_OKAY;
      else              resp_c = RESP_SLVERR;   // timeout

      w_go    = 1'b0;
      state_n = state;
      case (state)
         SLV_IDLE: begin
            if (rd_grant)
               state_n = SLV_R_ACCESS;
            else if (aw_hs && w_hs) begin
               state_n = SLV_W_ACCESS;
               w_go    = 1'b1;
            end else if (aw_hs || w_hs)
               state_n = SLV_W_COLLECT;
         end
         SLV_W_COLLECT: begin
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
               state_n = SLV_W_ACCESS;
               w_go    = 1'b1;
            end
         end
         SLV_W_ACCESS: if (acc_done)     state_n = SLV_W_RESP;
         SLV_W_RESP:   if (S_AXI_BREADY) state_n = SLV_IDLE;
         SLV_R_ACCESS: if (acc_done)     state_n = SLV_R_RESP;
         SLV_R_RESP:   if (S_AXI_RREADY) state_n = SLV_IDLE;
         default:                        state_n = SLV_IDLE;
      endcase
   end

   assign S_AXI_ARREADY = arready_c;
   assign S_AXI_AWREADY = awready_c;
   assign S_AXI_WREADY  = wready_c;

   axil_slv_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BASE_ADDR  (BASE_ADDR),
      .ADDR_SPAN  (ADDR_SPAN)
   ) u_dec (
      .addr     (acc_addr),
      .in_range (dec_hit),
      .offset   (dec_off)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SLV_IDLE;
      else     state <= state_n;
   end

   // -------------------------------------------------------------------------
   // Capture, register-bus request and AXI response registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_got       <= 1'b0;
         w_got        <= 1'b0;
         rd_prio      <= 1'b0;
         dec_err      <= 1'b0;
         aw_addr_q    <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         reg_req      <= 1'b0;
         reg_addr     <= '0;
         reg_wdata    <= '0;
         reg_wstrb    <= '0;
         reg_wr       <= 1'b0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
         S_AXI_RVALID <= 1'b0;
         S_AXI_RRESP  <= RESP_OKAY;
         S_AXI_RDATA  <= '0;
      end else begin
         if (contested && (rd_grant || aw_hs || w_hs))
            rd_prio <= ~rd_prio;

         if (aw_hs) begin
            aw_addr_q <= S_AXI_AWADDR;
            aw_got    <= 1'b1;
         end
         if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
            w_got   <= 1'b1;
         end

         // Launch: reg_req is high on the first ACCESS cycle unless the
         // address misses, in which case ACCESS idles one cycle.
         if (w_go) begin
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            reg_req   <= dec_hit;
            dec_err   <= ~dec_hit;
            reg_addr  <= dec_off;
            reg_wdata <= w_hs ? S_AXI_WDATA : wdata_q;
            reg_wstrb <= w_hs ? S_AXI_WSTRB : wstrb_q;
            reg_wr    <= 1'b1;
         end
         if (rd_grant) begin
            reg_req   <= dec_hit;
            dec_err   <= ~dec_hit;
            reg_addr  <= dec_off;
            reg_wdata <= '0;
            reg_wstrb <= '0;
            reg_wr    <= 1'b0;
         end

         if ((state == SLV_W_ACCESS || state == SLV_R_ACCESS) && acc_done) begin
            reg_req <= 1'b0;
            dec_err <= 1'b0;
            if (state == SLV_W_ACCESS) begin
               S_AXI_BVALID <= 1'b1;
               S_AXI_BRESP  <= resp_c;
            end else begin
               S_AXI_RVALID <= 1'b1;
               S_AXI_RRESP  <= resp_c;
               S_AXI_RDATA  <= (resp_c == RESP_OKAY) ? reg_rdata : 32'h0;
            end
         end

         if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
         if (S_AXI_RVALID && S_AXI_RREADY) S_AXI_RVALID <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // reg_ack watchdog
   // -------------------------------------------------------------------------
`ifdef AXIL_SLV_TIMEOUT_EN
   localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TO_W-1:0] to_cnt;

   // Counts cycles reg_req has been waiting; reg_req is low before every
   // launch so the count restarts from 0 for each access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    to_cnt <= '0;
      else if (reg_req && !reg_ack) to_cnt <= to_cnt + 1'b1;
      else                        to_cnt <= '0;
   end

   assign timeout_hit = reg_req && !reg_ack && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_to;
   assign unused_to   = ^TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
`endif

endmodule
